// File: rtl/dual_ram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM with clear sweep.
package dual_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Selects which register currently drives q.
  typedef enum logic [1:0] {
    Q_ZERO = 2'd0,
    Q_CORE = 2'd1,
    Q_BYP  = 2'd2
  } q_src_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

endpackage

// File: rtl/dual_ram_core.sv
// Plain storage array: one synchronous write port, one synchronous read port, no reset.
module dual_ram_core
  import dual_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read returns the pre-write word on a same-address collision; the top bypasses it.
  always_ff @(posedge clock) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dual_ram_clr.sv
// Simple dual-port RAM with write-first bypass and an optional zeroing sweep after reset.
module dual_ram_clr
  import dual_ram_pkg::*;
#(
  parameter int unsigned DATA_W         = 4,
  parameter int unsigned ADDR_W         = 3,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic              wren,
  input  logic [ADDR_W-1:0] rdaddress,
  input  logic              rden,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy
);

  localparam int unsigned        DEPTH     = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic [ADDR_W-1:0]  r_clear_ptr;
  logic [ADDR_W-1:0]  w_clear_ptr_nxt;

  logic               w_core_we;
  logic [ADDR_W-1:0]  w_core_waddr;
  logic [DATA_W-1:0]  w_core_wdata;
  logic               w_core_re;
  logic [DATA_W-1:0]  w_core_rdata;
  logic               w_collision;

  q_src_t             r_q_sel;
  logic [DATA_W-1:0]  r_byp_data;
  logic               r_q_valid;

  always_ff @(posedge clock) begin
    r_state     <= w_state_nxt;
    r_busy      <= w_busy_nxt;
    r_clear_ptr <= w_clear_ptr_nxt;
  end

  // Next state plus the write-port mux: the sweep owns the core write port during CLEAR.
  always_comb begin
    w_state_nxt     = r_state;
    w_busy_nxt      = r_busy;
    w_clear_ptr_nxt = r_clear_ptr;
    w_core_we       = 1'b0;
    w_core_waddr    = wraddress;
    w_core_wdata    = data;
    w_core_re       = 1'b0;
    if (reset) begin
      w_state_nxt     = CLEAR_ON_RESET ? CLEAR : READY;
      w_busy_nxt      = CLEAR_ON_RESET;
      w_clear_ptr_nxt = '0;
    end else begin
      case (r_state)
        CLEAR: begin
          w_core_we       = 1'b1;
          w_core_waddr    = r_clear_ptr;
          w_core_wdata    = '0;
          w_clear_ptr_nxt = r_clear_ptr + ADDR_W'(1);
          if (r_clear_ptr == LAST_ADDR) begin
            w_state_nxt = READY;
            w_busy_nxt  = 1'b0;
          end
        end
        READY: begin
          w_core_we = wren;
          w_core_re = rden;
        end
      endcase
    end
  end

  assign w_collision = wren && (wraddress == rdaddress);

  // q is steered from registered sources only, so nothing combinational reaches it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q_sel    <= Q_ZERO;
      r_byp_data <= '0;
      r_q_valid  <= 1'b0;
    end else begin
      r_q_valid <= w_core_re;
      if (w_core_re) begin
        r_q_sel    <= w_collision ? Q_BYP : Q_CORE;
        r_byp_data <= data;
      end
    end
  end

  always_comb begin
    q = '0;
    case (r_q_sel)
      Q_CORE:  q = w_core_rdata;
      Q_BYP:   q = r_byp_data;
      default: q = '0;
    endcase
  end

  assign q_valid = r_q_valid;
  assign busy    = r_busy;

  dual_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clock   (clock),
    .i_we    (w_core_we),
    .i_waddr (w_core_waddr),
    .i_wdata (w_core_wdata),
    .i_re    (w_core_re),
    .i_raddr (rdaddress),
    .o_rdata (w_core_rdata)
  );

endmodule

// File: tb/tb_dual_ram_clr.sv
// Bench for dual_ram_clr: default instance checked against a cycle model, plus corner instances.
module tb_dual_ram_clr;

  logic       clock;
  logic       reset;
  logic [3:0] data;
  logic [2:0] wraddress;
  logic       wren;
  logic [2:0] rdaddress;
  logic       rden;
  logic [3:0] q;
  logic       q_valid;
  logic       busy;

  logic        b_reset, b_wren, b_rden, b_q_valid, b_busy;
  logic [15:0] b_data, b_q;
  logic [4:0]  b_wraddress, b_rdaddress;

  logic       c_reset, c_wren, c_rden, c_q_valid, c_busy;
  logic [3:0] c_data, c_q;
  logic [0:0] c_wraddress, c_rdaddress;

  int checks = 0;
  int errors = 0;

  dual_ram_clr u_dut (
    .clock(clock), .reset(reset), .data(data), .wraddress(wraddress), .wren(wren),
    .rdaddress(rdaddress), .rden(rden), .q(q), .q_valid(q_valid), .busy(busy)
  );

  dual_ram_clr #(.DATA_W(16), .ADDR_W(5), .CLEAR_ON_RESET(1'b0)) u_dut_b (
    .clock(clock), .reset(b_reset), .data(b_data), .wraddress(b_wraddress), .wren(b_wren),
    .rdaddress(b_rdaddress), .rden(b_rden), .q(b_q), .q_valid(b_q_valid), .busy(b_busy)
  );

  dual_ram_clr #(.DATA_W(4), .ADDR_W(1), .CLEAR_ON_RESET(1'b1)) u_dut_c (
    .clock(clock), .reset(c_reset), .data(c_data), .wraddress(c_wraddress), .wren(c_wren),
    .rdaddress(c_rdaddress), .rden(c_rden), .q(c_q), .q_valid(c_q_valid), .busy(c_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model of the default instance: memory array plus a count of sweep writes left.
  logic [3:0] m_mem [8];
  bit         m_known [8];
  int         m_sweep = 0;
  logic [3:0] m_q = '0;
  bit         m_qv = 0;
  bit         m_q_known = 0;
  bit         m_live = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_sweep   = 8;
      m_q       = '0;
      m_qv      = 0;
      m_q_known = 1;
      m_live    = 1;
    end else if (m_sweep > 0) begin
      m_mem[8 - m_sweep]   = '0;
      m_known[8 - m_sweep] = 1;
      m_sweep              = m_sweep - 1;
      m_qv                 = 0;
    end else begin
      if (rden) begin
        if (wren && (wraddress == rdaddress)) begin
          m_q       = data;
          m_q_known = 1;
        end else begin
          m_q       = m_mem[rdaddress];
          m_q_known = m_known[rdaddress];
        end
        m_qv = 1;
      end else begin
        m_qv = 0;
      end
      if (wren) begin
        m_mem[wraddress]   = data;
        m_known[wraddress] = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      chk("model_busy", 32'(busy), 32'(m_sweep > 0));
      chk("model_q_valid", 32'(q_valid), 32'(m_qv));
      if (m_q_known) chk("model_q", 32'(q), 32'(m_q));
    end
  end

  task automatic drive(input logic rst, input logic we, input logic [2:0] wa, input logic [3:0] d,
                       input logic re, input logic [2:0] ra);
    reset     = rst;
    wren      = we;
    wraddress = wa;
    data      = d;
    rden      = re;
    rdaddress = ra;
    @(negedge clock);
  endtask

  task automatic sweep_len(output int n);
    n = 0;
    while (busy && n < 20) begin
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
      n++;
    end
  endtask

  int n;

  initial begin
    for (int i = 0; i < 8; i++) m_known[i] = 0;
    reset = 1'b1; wren = 1'b0; rden = 1'b0; data = '0; wraddress = '0; rdaddress = '0;
    b_reset = 1'b1; b_wren = 1'b0; b_rden = 1'b0; b_data = '0; b_wraddress = '0; b_rdaddress = '0;
    c_reset = 1'b1; c_wren = 1'b0; c_rden = 1'b0; c_data = '0; c_wraddress = '0; c_rdaddress = '0;
    @(negedge clock);

    drive(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    sweep_len(n);
    chk("sweep_edges", 32'(n), 32'd8);

    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 3'(i));
      chk("cleared_q", 32'(q), 32'd0);
      chk("cleared_q_valid", 32'(q_valid), 32'd1);
    end

    drive(1'b0, 1'b1, 3'd5, 4'hA, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 3'd5);
    chk("rd5_q", 32'(q), 32'hA);
    chk("rd5_q_valid", 32'(q_valid), 32'd1);
    drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
    chk("hold_q", 32'(q), 32'hA);
    chk("hold_q_valid", 32'(q_valid), 32'd0);

    drive(1'b0, 1'b1, 3'd2, 4'h3, 1'b1, 3'd2);
    chk("bypass_q", 32'(q), 32'h3);
    drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 3'd2);
    chk("after_bypass_q", 32'(q), 32'h3);

    drive(1'b0, 1'b1, 3'd1, 4'h5, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
    drive(1'b0, 1'b1, 3'd1, 4'hF, 1'b1, 3'd1);
    chk("busy_q_valid", 32'(q_valid), 32'd0);
    chk("busy_flag", 32'(busy), 32'd1);
    sweep_len(n);
    chk("busy_wait", 32'(n < 20), 32'd1);
    drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 3'd1);
    chk("ignored_write_q", 32'(q), 32'd0);

    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 3'(i), 4'(i + 1), 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 3'(i));
      chk("fill_q", 32'(q), 32'(i + 1));
    end
    drive(1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 3'd3);
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_q_valid", 32'(q_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    sweep_len(n);
    chk("midrst_sweep_edges", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 3'(i));
      chk("resweep_q", 32'(q), 32'd0);
    end
    drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);

    // Wide, no-sweep instance.
    @(negedge clock);
    chk("b_rst_busy", 32'(b_busy), 32'd0);
    b_reset = 1'b0; b_wren = 1'b1; b_wraddress = 5'd31; b_data = 16'hBEEF;
    @(negedge clock);
    chk("b_busy", 32'(b_busy), 32'd0);
    b_wren = 1'b0; b_rden = 1'b1; b_rdaddress = 5'd31;
    @(negedge clock);
    chk("b_q", 32'(b_q), 32'h0000BEEF);
    chk("b_q_valid", 32'(b_q_valid), 32'd1);
    chk("b_busy_end", 32'(b_busy), 32'd0);
    b_rden = 1'b0;

    // Two-word instance.
    @(negedge clock);
    chk("c_rst_busy", 32'(c_busy), 32'd1);
    c_reset = 1'b0;
    n = 0;
    while (c_busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("c_sweep_edges", 32'(n), 32'd2);
    c_wren = 1'b1; c_wraddress = 1'b1; c_data = 4'h9;
    @(negedge clock);
    c_wren = 1'b0; c_rden = 1'b1; c_rdaddress = 1'b1;
    @(negedge clock);
    chk("c_q", 32'(c_q), 32'h9);
    c_rdaddress = 1'b0;
    @(negedge clock);
    chk("c_q0", 32'(c_q), 32'h0);
    c_rden = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
